// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings, FSM states and default width for the ALU arbiter
package alu_pkg;
    localparam int ALU_WIDTH = 32;
    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_AND = 1'b1;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-way combinational arbiter producing a one-hot grant
// Ports: valid[1:0] requests, last last-served index, en grant enable, grant[1:0] one-hot grant.
// Policy: ALU_ARB_RR_EN defined -> round-robin on last; undefined -> fixed priority to requester 0.
module arb_rr2 (
    input  logic [1:0] valid,
    input  logic       last,
    input  logic       en,
    output logic [1:0] grant
);
`ifdef ALU_ARB_RR_EN
    // on a tie the requester that was not served last wins
    assign grant[0] = en && valid[0] && (!valid[1] || last);
    assign grant[1] = en && valid[1] && (!valid[0] || !last);
`else
    logic unused_last;
    assign unused_last = last;
    assign grant[0]    = en && valid[0];
    assign grant[1]    = en && valid[1] && !valid[0];
`endif
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: arbitrates two requesters onto one shared ALU and returns the result
// Ports: clk/rst_n (async active-low), reqN_valid/ready/a/b/op request handshakes,
// rspN_valid/ready response handshakes with shared rsp_result, alu_a/alu_b/alu_op
// registered ALU operands, alu_result combinational ALU output.
// ALU_ARB_RR_EN defined selects round-robin arbitration, otherwise fixed priority.
import alu_pkg::*;
module alu_arbiter #(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req0_op,
    input  logic             req1_op,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_op,
    input  logic [WIDTH-1:0] alu_result
);
    state_t     state, state_d;
    logic       owner, last;
    logic [1:0] grant;
    logic       rsp_done;
    // rst_n gates the enable so both readies read 0 while reset is held
    arb_rr2 u_arb (
        .valid({req1_valid, req0_valid}),
        .last (last),
        .en   (state == IDLE && rst_n),
        .grant(grant)
    );
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = state == RESP && !owner;
    assign rsp1_valid = state == RESP && owner;
    assign rsp_done   = owner ? rsp1_ready : rsp0_ready;
    always_comb begin
        state_d = IDLE;
        case (state)
            IDLE:    state_d = |grant ? EXEC : IDLE;
            EXEC:    state_d = RESP;
            RESP:    state_d = rsp_done ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            last       <= 1'b1;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= ALU_OP_ADD;
            rsp_result <= '0;
        end else if (state == IDLE && |grant) begin
            owner  <= grant[1];
            alu_a  <= grant[1] ? req1_a : req0_a;
            alu_b  <= grant[1] ? req1_b : req0_b;
            alu_op <= grant[1] ? req1_op : req0_op;
        end else if (state == EXEC) begin
            rsp_result <= alu_result;
        end else if (state == RESP && rsp_done) begin
            last <= owner;
        end
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ALU (op 0 = add, op 1 = AND). It accepts operation requests over valid/ready handshakes, grants one requester at a time and registers the operands that drive the ALU. It captures the ALU result and returns it to the granted requester over a response handshake. It sits between the execute-stage issue logic and the single combinational ALU instance.

## Interface
- `WIDTH`, 32, operand/result width
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `req0_valid`, `req1_valid`  in  1  request present
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands
- `req0_op`, `req1_op`  in  1  0 = add, 1 = AND
- `rsp0_valid`, `rsp1_valid`  out  1  result ready for requester 0 / 1
- `rsp0_ready`, `rsp1_ready`  in  1  requester consumes result
- `rsp_result`  out  WIDTH  shared result bus, valid with the owner's `rspN_valid`
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU
- `alu_op`  out  1  registered operation to the ALU
- `alu_result`  in  WIDTH  combinational ALU output

## Operation
- FSM states:
  - IDLE: arbitrate.
    - On a request handshake, latch a/b/op into `alu_a`/`alu_b`/`alu_op` and latch owner. Go to EXEC.
  - EXEC: one cycle.
    - Capture `alu_result` into `rsp_result`. Go to RESP.
  - RESP: assert owner's `rspN_valid`.
    - On `rspN_ready`, go to IDLE and record the owner as last-served.
- `reqN_ready` = (state == IDLE) && grant to N. It is combinational from the valids and the last-served pointer. At most one ready is high.
- Requesters must hold valid and operands stable until ready. Valid must not depend on ready.
- Arbitration (round-robin build):
  - Both valid: grant the requester not last-served.
  - One valid: grant it.
- Last-served pointer resets to 1, so req0 wins the first tie.
- The non-owner's `rspN_valid` stays 0. `rsp_result` holds its value outside RESP.
- Add wraps modulo 2^WIDTH, with no carry out. AND is bitwise.
- Reset values:
  - state IDLE
  - all `reqN_ready`, `rspN_valid` = 0
  - `rsp_result`, `alu_a`, `alu_b` = 0, `alu_op` = 0
  - owner 0, last-served 1
- Reset mid-transaction: the operation is dropped and no response is issued. The requester must re-issue.

## Timing
- Request accepted at edge E0 (valid & ready high in the cycle before E0).
- ALU inputs are valid after E0. The result is captured at E1. `rspN_valid` is high after E1, a latency of 2 cycles from the accept edge.
- If `rspN_ready` is high at E2, the response completes. The state is IDLE after E2, and the earliest next accept is edge E3. Peak throughput is 1 operation per 3 cycles.
- `rspN_ready` low holds RESP indefinitely. Result and valid stay stable, and both `reqN_ready` stay 0.
- A request arriving during EXEC or RESP waits. It is evaluated in the first IDLE cycle.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration as above.
- Undefined: fixed priority. req0 always wins when both are valid. The last-served pointer is still maintained but ignored. req1 can starve under continuous req0 traffic.

## Structure
- Shared package `alu_pkg` holds:
  - the op encodings `ALU_OP_ADD` = 1'b0 and `ALU_OP_AND` = 1'b1
  - the FSM state encodings (IDLE, EXEC, RESP, 2 bits)
  - the default `WIDTH`
- One sub-module, `arb_rr2`. It takes the two valids, the last-served pointer and the enable, and produces one-hot grant. It is purely combinational, and the macro selects its policy.
- The FSM, operand registers and result register stay in `alu_arbiter`.

## Test plan
- Single add: req0 with a = 20000, b = 30000, op = 0. Expect `req0_ready` for 1 cycle, then `rsp0_valid` 2 cycles after accept with `rsp_result` = 50000. `rsp1_valid` stays 0.
- Single AND: req1 with a = 0x6DB (0b11011011011), b = 0x36D (0b01101101101), op = 1. Expect `rsp1_valid` with `rsp_result` = 0x249 (585).
- Tie: both valid continuously with distinct operands.
  - `ALU_ARB_RR_EN`: grants alternate 0, 1, 0, 1.
  - Without the macro: four consecutive grants to req0.
- Backpressure: hold `rsp0_ready` = 0 for 5 cycles. `rsp0_valid` and `rsp_result` remain stable, both `reqN_ready` stay 0, and the response completes on the cycle ready rises.
- Overflow: a = 0xFFFFFFFF, b = 1, op = 0. Expect `rsp_result` = 0x00000000.
- Reset during EXEC: pulse `rst_n` low. All outputs go to 0 immediately, no `rspN_valid` follows, and the next request is served normally with req0 winning a tie.
